div_seq_ctrl: RTL and testbench

//  Sequencing controller for the restoring divider datapath. Accepts a dividend/divisor pair,

---
 rtl/div_seq_ctrl.sv | 136 +++++++++++++
 tb/tb_div_seq_ctrl.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/div_seq_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | div_seq_ctrl                                                           |
// | Sequencing controller for a restoring divider: one quotient bit per    |
// | DRIVE/GAP pair, MSB first, driving a shift-command bus and clear pulse.|
// | Optional: DIV_SEQ_ZERO_CHECK_EN enables the divide-by-zero fast path.  |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module div_seq_ctrl #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic         out_clr,
  output logic [1:0]   qbit_cmd,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         dz_err
);

  localparam int c_kw = $clog2(N);

  localparam logic [2:0] c_st_idle  = 3'd0;
  localparam logic [2:0] c_st_clr   = 3'd1;
  localparam logic [2:0] c_st_drive = 3'd2;
  localparam logic [2:0] c_st_gap   = 3'd3;
  localparam logic [2:0] c_st_done  = 3'd4;

  logic [2:0]      r_state;
  logic [2:0]      w_state_nxt;
  logic [c_kw-1:0] r_k;
  logic [c_kw-1:0] w_k_sel;
  logic [N-1:0]    r_dvd;
  logic [N-1:0]    r_dsr;
  logic [N-1:0]    r_rem;
  logic [N-1:0]    r_q;
  logic [1:0]      r_cmd;
  logic [N:0]      w_shift;
  logic [N-1:0]    w_diff;
  logic [N-1:0]    w_rem_nxt;
  logic            w_ge;
  logic            w_zero_trap;

`ifdef DIV_SEQ_ZERO_CHECK_EN
  assign w_zero_trap = (divisor == '0);
`else
  assign w_zero_trap = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= c_st_idle;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_idle:  if (start) w_state_nxt = w_zero_trap ? c_st_done : c_st_clr;
      c_st_clr:   w_state_nxt = c_st_drive;
      c_st_drive: w_state_nxt = c_st_gap;
      c_st_gap:   w_state_nxt = (r_k == '0) ? c_st_done : c_st_drive;
      c_st_done:  w_state_nxt = c_st_idle;
      default:    w_state_nxt = c_st_idle;
    endcase
  end

  always_comb begin
    busy    = (r_state != c_st_idle);
    done    = (r_state == c_st_done);
    out_clr = (r_state == c_st_clr);
  end

  assign qbit_cmd = r_cmd;

  // The step is evaluated on the edge entering DRIVE so the command is a
  // register output for the whole DRIVE cycle; CLR enters with k=N-1.
  assign w_k_sel   = (r_state == c_st_clr) ? r_k : (r_k - c_kw'(1));
  assign w_shift   = {r_rem, r_dvd[w_k_sel]};
  assign w_ge      = (w_shift >= {1'b0, r_dsr});
  assign w_diff    = w_shift[N-1:0] - r_dsr;
  assign w_rem_nxt = w_ge ? w_diff : w_shift[N-1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_k       <= '0;
      r_dvd     <= '0;
      r_dsr     <= '0;
      r_rem     <= '0;
      r_q       <= '0;
      r_cmd     <= 2'b00;
      quotient  <= '0;
      remainder <= '0;
    end else begin
      if (r_state == c_st_idle && start) begin
        r_dvd <= dividend;
        r_dsr <= divisor;
        r_rem <= '0;
        r_q   <= '0;
        r_k   <= c_kw'(N - 1);
        if (w_zero_trap) begin
          quotient  <= '1;
          remainder <= dividend;
        end
      end
      if (r_state == c_st_drive) r_cmd <= 2'b00;
      if (w_state_nxt == c_st_drive) begin
        r_k          <= w_k_sel;
        r_rem        <= w_rem_nxt;
        r_q[w_k_sel] <= w_ge;
        r_cmd        <= w_ge ? 2'b10 : 2'b01;
      end
      if (r_state == c_st_gap && w_state_nxt == c_st_done) begin
        quotient  <= r_q;
        remainder <= r_rem;
      end
    end
  end

`ifdef DIV_SEQ_ZERO_CHECK_EN
  logic r_dz;
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                          r_dz <= 1'b0;
    else if (r_state == c_st_idle && start) r_dz <= w_zero_trap;
  end
  assign dz_err = r_dz;
`else
  assign dz_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_div_seq_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_div_seq_ctrl                                                        |
// | Directed self-checking bench for div_seq_ctrl (N=8).                   |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module tb_div_seq_ctrl;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [N-1:0] dividend = '0;
  logic [N-1:0] divisor = '0;
  logic         busy, done, out_clr, dz_err;
  logic [1:0]   qbit_cmd;
  logic [N-1:0] quotient, remainder;

  int n_cmp = 0;
  int n_bad = 0;

  div_seq_ctrl #(.N(N)) dut (
    .clk(clk), .reset(reset), .start(start), .dividend(dividend),
    .divisor(divisor), .busy(busy), .done(done), .out_clr(out_clr),
    .qbit_cmd(qbit_cmd), .quotient(quotient), .remainder(remainder),
    .dz_err(dz_err)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Runs one operation; the trace packs {busy,out_clr,done,cmd} per cycle t+1..t+2N+2.
  task automatic run_op(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                        input logic [N-1:0] eq, input logic [N-1:0] er,
                        input int pulse_at, input bit hold,
                        input logic [N-1:0] a2, input logic [N-1:0] b2);
    logic [127:0] tr_obs;
    logic [127:0] tr_exp;
    logic [1:0]   ecmd;
    tr_obs = '0;
    tr_exp = '0;
    @(negedge clk);
    start = 1'b1; dividend = a; divisor = b;
    @(negedge clk);
    dividend = a2; divisor = b2;
    for (int c = 1; c <= 2*N+2; c++) begin
      if (c > 1) @(negedge clk);
      start = hold || (c == pulse_at);
      ecmd = 2'b00;
      if (c >= 2 && c <= 2*N && (c % 2) == 0)
        ecmd = eq[N-1-(c-2)/2] ? 2'b10 : 2'b01;
      tr_obs = {tr_obs[122:0], busy, out_clr, done, qbit_cmd};
      tr_exp = {tr_exp[122:0], 1'b1, (c == 1), (c == 2*N+2), ecmd};
    end
    check_val({tag, "_trace"}, tr_obs, tr_exp);
    check_val({tag, "_q"}, 128'(quotient), 128'(eq));
    check_val({tag, "_r"}, 128'(remainder), 128'(er));
    check_val({tag, "_dz"}, 128'(dz_err), 128'(0));
    @(negedge clk);
    check_val({tag, "_idle"}, 128'({busy, done}), 128'(0));
  endtask

  initial begin
    #1;
    check_val("reset_state", 128'({busy, done, out_clr, qbit_cmd, quotient, remainder, dz_err}), 128'(0));
    repeat (2) @(negedge clk);
    reset = 1'b0;

    run_op("d100_7",   8'd100, 8'd7,   8'd14,  8'd2,  0, 1'b0, 8'hA5, 8'h00);
    run_op("d255_1",   8'd255, 8'd1,   8'd255, 8'd0,  0, 1'b0, 8'h00, 8'h03);
    run_op("d0_5",     8'd0,   8'd5,   8'd0,   8'd0,  0, 1'b0, 8'hFF, 8'h01);
    run_op("d5_200",   8'd5,   8'd200, 8'd0,   8'd5,  0, 1'b0, 8'h77, 8'h02);
    run_op("d200_200", 8'd200, 8'd200, 8'd1,   8'd0,  0, 1'b0, 8'h10, 8'h20);

`ifdef DIV_SEQ_ZERO_CHECK_EN
    @(negedge clk);
    start = 1'b1; dividend = 8'd37; divisor = 8'd0;
    @(negedge clk);
    start = 1'b0; dividend = 8'd0; divisor = 8'd9;
    check_val("dz_fast", 128'({busy, out_clr, done, qbit_cmd, quotient, remainder, dz_err}),
              128'({1'b1, 1'b0, 1'b1, 2'b00, 8'd255, 8'd37, 1'b1}));
    @(negedge clk);
    check_val("dz_idle", 128'({busy, done, qbit_cmd, dz_err}), 128'({1'b0, 1'b0, 2'b00, 1'b1}));
`else
    run_op("d37_0",    8'd37,  8'd0,   8'd255, 8'd37, 0, 1'b0, 8'h55, 8'h04);
`endif

    // Stray start mid-operation is ignored.
    run_op("pulse",    8'd100, 8'd7,   8'd14,  8'd2,  5, 1'b0, 8'd1,  8'd1);

    // Start held high: the second operation is accepted at t+19 with new operands.
    run_op("hold",     8'd100, 8'd7,   8'd14,  8'd2,  0, 1'b1, 8'd9,  8'd2);
    @(negedge clk);
    start = 1'b0;
    check_val("hold_accept", 128'({busy, out_clr}), 128'(2'b11));
    begin
      int waited;
      waited = 0;
      while (!done && waited < 40) begin
        @(negedge clk);
        waited++;
      end
      check_val("hold_done_lat", 128'(waited), 128'(2*N+1));
      check_val("hold_q", 128'({quotient, remainder}), 128'({8'd4, 8'd1}));
    end

    // Asynchronous reset mid-operation.
    @(negedge clk);
    start = 1'b1; dividend = 8'd100; divisor = 8'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    reset = 1'b1;
    #1;
    check_val("rst_mid", 128'({busy, done, out_clr, qbit_cmd, quotient, remainder, dz_err}), 128'(0));
    @(negedge clk);
    reset = 1'b0;
    begin
      int seen;
      seen = 0;
      repeat (14) begin
        @(negedge clk);
        seen += int'(done);
      end
      check_val("rst_no_done", 128'(seen), 128'(0));
    end
    run_op("d9_2",     8'd9,   8'd2,   8'd4,   8'd1,  0, 1'b0, 8'h00, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
